// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// usr_pkg : mode and frame-direction encodings for universal_shift_register
// Revision: 1.0
// ============================================================================
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_R    = 2'b01,
    DIR_L    = 2'b10
  } dir_t;

endpackage
`default_nettype wire

// File: rtl/usr_frame_tracker.sv
`default_nettype none
// ============================================================================
// usr_frame_tracker : counts consecutive same-direction shifts, pulses per frame
// Revision: 1.0
// ============================================================================
module usr_frame_tracker
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift_r,
  input  logic             shift_l,
  input  logic             load,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  dir_t             new_dir;

  always_ff @(posedge clk) begin
    if (clr) begin
      dir_q  <= DIR_NONE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // A direction change starts a new frame with this shift as its first bit.
  always_comb begin
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    new_dir = shift_r ? DIR_R : DIR_L;
    if (load) begin
      dir_d = DIR_NONE;
      cnt_d = '0;
    end else if (shift_r || shift_l) begin
      if (dir_q == new_dir) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        dir_d = new_dir;
        cnt_d = CNT_ONE;
      end
    end
  end

  always_comb begin
    shift_cnt  = cnt_q;
    frame_done = done_q;
  end

endmodule
`default_nettype wire

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// universal_shift_register : hold / shift right / shift left / load with frames
// Revision: 1.0
// ============================================================================
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             do_shr, do_shl, do_load;

  assign do_shr  = en && (mode == MODE_SHR);
  assign do_shl  = en && (mode == MODE_SHL);
  assign do_load = en && (mode == MODE_LOAD);

  always_comb begin
    q_d = q_q;
    if (do_shr) begin
      q_d = {rot ? q_q[0] : sin_r, q_q[WIDTH-1:1]};
    end else if (do_shl) begin
      q_d = {q_q[WIDTH-2:0], rot ? q_q[WIDTH-1] : sin_l};
    end else if (do_load) begin
      q_d = pin;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

  usr_frame_tracker #(
    .WIDTH (WIDTH)
  ) u_frame_tracker (
    .clk        (clk),
    .clr        (clr),
    .shift_r    (do_shr),
    .shift_l    (do_shl),
    .load       (do_load),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// tb_universal_shift_register : WIDTH=8 and WIDTH=4 instances vs. run-length model
// Revision: 1.0
// ============================================================================
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       clr, en, rot, sin_r, sin_l;
  logic [1:0] mode;
  logic [7:0] pin8;
  logic [3:0] pin4;

  logic [7:0] q8;
  logic       sout_r8, sout_l8, done8;
  logic [3:0] cnt8;
  logic [3:0] q4;
  logic       sout_r4, sout_l4, done4;
  logic [2:0] cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: data as an integer, frames as an unbounded run length.
  int mw[2] = '{8, 4};
  int mq[2];
  int mdir[2];
  int mlen[2];
  int mdone[2];

  always #5 clk = ~clk;
  assign pin4 = pin8[3:0];

  universal_shift_register #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .rot(rot),
    .sin_r(sin_r), .sin_l(sin_l), .pin(pin8), .q(q8),
    .sout_r(sout_r8), .sout_l(sout_l8), .shift_cnt(cnt8), .frame_done(done8)
  );

  universal_shift_register #(.WIDTH(4)) u_dut4 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .rot(rot),
    .sin_r(sin_r), .sin_l(sin_l), .pin(pin4), .q(q4),
    .sout_r(sout_r4), .sout_l(sout_l4), .shift_cnt(cnt4), .frame_done(done4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input int k);
    int w, mask, inb, d;
    w    = mw[k];
    mask = (1 << w) - 1;
    if (clr) begin
      mq[k] = 0; mdir[k] = 0; mlen[k] = 0; mdone[k] = 0;
    end else if (!en || mode == 2'b00) begin
      mdone[k] = 0;
    end else if (mode == 2'b11) begin
      mq[k] = int'(pin8) & mask; mdir[k] = 0; mlen[k] = 0; mdone[k] = 0;
    end else begin
      if (mode == 2'b01) begin
        inb   = rot ? (mq[k] & 1) : int'(sin_r);
        mq[k] = (mq[k] >> 1) | (inb << (w - 1));
        d     = 1;
      end else begin
        inb   = rot ? ((mq[k] >> (w - 1)) & 1) : int'(sin_l);
        mq[k] = ((mq[k] << 1) | inb) & mask;
        d     = 2;
      end
      if (d != mdir[k]) begin
        mdir[k] = d;
        mlen[k] = 1;
      end else begin
        mlen[k]++;
      end
      mdone[k] = ((mlen[k] % w) == 0) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    check("q8",      32'(q8),      32'(mq[0]));
    check("sout_r8", 32'(sout_r8), 32'(mq[0] & 1));
    check("sout_l8", 32'(sout_l8), 32'((mq[0] >> 7) & 1));
    check("cnt8",    32'(cnt8),    32'(mlen[0] % 8));
    check("done8",   32'(done8),   32'(mdone[0]));
    check("q4",      32'(q4),      32'(mq[1]));
    check("sout_r4", 32'(sout_r4), 32'(mq[1] & 1));
    check("sout_l4", 32'(sout_l4), 32'((mq[1] >> 3) & 1));
    check("cnt4",    32'(cnt4),    32'(mlen[1] % 4));
    check("done4",   32'(done4),   32'(mdone[1]));
  endtask

  task automatic step(input bit c, input bit e, input logic [1:0] m, input bit r,
                      input bit sr, input bit sl, input logic [7:0] p);
    clr = c; en = e; mode = m; rot = r; sin_r = sr; sin_l = sl; pin8 = p;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] exp_q[4];
    logic [2:0] exp_c[4];
    bit         sr_seq[4];
    int         pulses;
    exp_q  = '{4'h8, 4'h4, 4'hA, 4'hD};
    exp_c  = '{3'd1, 3'd2, 3'd3, 3'd0};
    sr_seq = '{1'b1, 1'b0, 1'b1, 1'b1};

    clr = 1'b1; en = 1'b0; mode = 2'b00; rot = 1'b0; sin_r = 1'b0; sin_l = 1'b0; pin8 = 8'h00;
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; mdir[k] = 0; mlen[k] = 0; mdone[k] = 0;
    end
    step(1, 0, 2'b00, 0, 0, 0, 8'h00);

    // Reset from a full register with en low.
    step(0, 1, 2'b11, 0, 0, 0, 8'hFF);
    check("pre_clr_q8", 32'(q8), 32'hFF);
    step(1, 0, 2'b00, 0, 0, 0, 8'h00);
    check("clr_q8",    32'(q8),    32'h00);
    check("clr_cnt8",  32'(cnt8),  32'h0);
    check("clr_done8", 32'(done8), 32'h0);

    // Plain shifts.
    step(0, 1, 2'b11, 0, 0, 0, 8'hA5);
    step(0, 1, 2'b01, 0, 1, 0, 8'h00);
    check("shr_a5", 32'(q8), 32'hD2);
    step(0, 1, 2'b11, 0, 0, 0, 8'hA5);
    step(0, 1, 2'b10, 0, 0, 0, 8'h00);
    check("shl_a5", 32'(q8), 32'h4A);

    // Rotates ignore the serial inputs.
    step(0, 1, 2'b11, 0, 0, 0, 8'h81);
    step(0, 1, 2'b01, 1, 0, 1, 8'h00);
    check("rotr_81", 32'(q8), 32'hC0);
    step(0, 1, 2'b11, 0, 0, 0, 8'h81);
    step(0, 1, 2'b10, 1, 1, 0, 8'h00);
    check("rotl_81", 32'(q8), 32'h03);

    // WIDTH=4 frame: q and count sequences, pulse on the fourth shift.
    step(1, 0, 2'b00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'b01, 0, sr_seq[i], 0, 8'h00);
      check("frm_q4",    32'(q4),    32'(exp_q[i]));
      check("frm_cnt4",  32'(cnt4),  32'(exp_c[i]));
      check("frm_done4", 32'(done4), (i == 3) ? 32'd1 : 32'd0);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'b01, 0, 1, 0, 8'h00);
      pulses += int'(done4);
    end
    check("frm2_pulses4", 32'(pulses), 32'd1);
    check("frm2_last4",   32'(done4),  32'd1);

    // Direction change restarts the frame.
    step(1, 0, 2'b00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 0, 0, 0, 8'h00);
    step(0, 1, 2'b10, 0, 0, 1, 8'h00);
    check("dirchg_cnt4",  32'(cnt4),  32'd1);
    check("dirchg_done4", 32'(done4), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b10, 0, 0, 1, 8'h00);
      check("dirchg_pulse4", 32'(done4), (i == 2) ? 32'd1 : 32'd0);
    end

    // Mid-frame clr and load discard the partial frame; en=0 gaps are transparent.
    for (int v = 0; v < 2; v++) begin
      step(1, 0, 2'b00, 0, 0, 0, 8'h00);
      step(0, 1, 2'b01, 0, 1, 0, 8'h00);
      step(0, 1, 2'b01, 0, 1, 0, 8'h00);
      if (v == 0) step(1, 1, 2'b01, 0, 1, 0, 8'h00);
      else        step(0, 1, 2'b11, 0, 0, 0, 8'h05);
      check("abort_cnt4",  32'(cnt4),  32'd0);
      check("abort_done4", 32'(done4), 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        step(0, 1, 2'b01, 0, 0, 0, 8'h00);
        pulses += int'(done4);
        if (i == 1) begin
          step(0, 0, 2'b01, 0, 1, 1, 8'h00);
          check("gap_cnt4", 32'(cnt4), 32'd2);
          step(0, 1, 2'b00, 0, 1, 1, 8'h00);
          check("hold_cnt4", 32'(cnt4), 32'd2);
        end
      end
      check("abort_pulses4", 32'(pulses), 32'd1);
    end

    // Randomized traffic, biased towards long same-direction runs.
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [1:0] m;
      r = int'($urandom_range(0, 99));
      if (r < 40)      m = 2'b01;
      else if (r < 75) m = 2'b10;
      else if (r < 88) m = 2'b00;
      else             m = 2'b11;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0), m,
           ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
